// File: rtl/sme_param_pkg.sv
// Shared definitions for the sme_param string-matching engine:
//   - meta-character codes recognised in patterns
//   - the controller state encoding
//   - an ASCII case-fold helper used by the compare step
package sme_pkg;

    localparam int META_CARET  = 32'h5E;  // '^' zero-width: start of string or after a space
    localparam int META_DOLLAR = 32'h24;  // '$' zero-width: end of string or before a space
    localparam int META_DOT    = 32'h2E;  // '.' any single character
    localparam int META_STAR   = 32'h2A;  // '*' any run of characters, including none
    localparam int META_SPACE  = 32'h20;  // word separator seen by '^' and '$'

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Map ASCII 'A'..'Z' onto 'a'..'z'; every other code passes through,
    // so meta characters are never altered.
    function automatic int unsigned fold_case(input int unsigned c);
        if (c >= 32'h41 && c <= 32'h5A) begin
            return c + 32'h20;
        end
        return c;
    endfunction

endpackage

// File: rtl/sme_param_if.sv
// Byte-serial load / result bus of the sme_param matcher.
//   chardata    character being loaded
//   isstring    chardata is a string character this cycle
//   ispattern   chardata is a pattern character this cycle
//   busy        search in progress, loads are ignored
//   valid       one-cycle result strobe
//   match       result, qualified by valid
//   match_index leftmost match start, qualified by valid
// master: the loader/consumer side. slave: the matcher.
interface sme_if #(
    parameter int CW      = 8,
    parameter int MAX_STR = 32
);
    localparam int IW = (MAX_STR > 1) ? $clog2(MAX_STR) : 1;

    logic [CW-1:0] chardata;
    logic          isstring;
    logic          ispattern;
    logic          busy;
    logic          valid;
    logic          match;
    logic [IW-1:0] match_index;

    modport master (
        output chardata, isstring, ispattern,
        input  busy, valid, match, match_index
    );

    modport slave (
        input  chardata, isstring, ispattern,
        output busy, valid, match, match_index
    );
endinterface

// File: rtl/sme_param_step.sv
// One matcher step: given the current search pointers and the characters
// they address, produce the pointers for the next clock and flag completion.
//   i_slen/i_plen      loaded string / pattern lengths
//   i_st               candidate start
//   i_si/i_pi          string / pattern cursors
//   i_star_s/i_star_p  resume points of the most recent '*'
//   i_sp_valid         a '*' has been seen in this candidate
//   i_pc               pattern character at i_pi
//   i_sc               string character at i_si (only meaningful when i_si < i_slen)
//   i_sc_prev          string character at i_si-1 (only meaningful when i_si > 0)
//   o_*                next values of the pointers
//   o_done/o_found     search finished this step / with a match at i_st
module sme_step
    import sme_pkg::*;
#(
    parameter int CW     = 8,
    parameter int LW     = 6,
    parameter int PW     = 4,
    parameter int NOCASE = 0
) (
    input  logic [LW-1:0] i_slen,
    input  logic [PW-1:0] i_plen,
    input  logic [LW-1:0] i_st,
    input  logic [LW-1:0] i_si,
    input  logic [LW-1:0] i_star_s,
    input  logic [PW-1:0] i_pi,
    input  logic [PW-1:0] i_star_p,
    input  logic          i_sp_valid,
    input  logic [CW-1:0] i_pc,
    input  logic [CW-1:0] i_sc,
    input  logic [CW-1:0] i_sc_prev,
    output logic [LW-1:0] o_st,
    output logic [LW-1:0] o_si,
    output logic [LW-1:0] o_star_s,
    output logic [PW-1:0] o_pi,
    output logic [PW-1:0] o_star_p,
    output logic          o_sp_valid,
    output logic          o_done,
    output logic          o_found
);

    logic [CW-1:0] w_pc_cmp;
    logic [CW-1:0] w_sc_cmp;
    logic          w_pass;
    logic          w_adv_s;

    // Folding only feeds the literal-character compare; meta decoding uses i_pc.
    always_comb begin
        w_pc_cmp = i_pc;
        w_sc_cmp = i_sc;
        if (NOCASE != 0) begin
            w_pc_cmp = CW'(fold_case(32'(i_pc)));
            w_sc_cmp = CW'(fold_case(32'(i_sc)));
        end
    end

    always_comb begin
        o_st       = i_st;
        o_si       = i_si;
        o_star_s   = i_star_s;
        o_pi       = i_pi;
        o_star_p   = i_star_p;
        o_sp_valid = i_sp_valid;
        o_done     = 1'b0;
        o_found    = 1'b0;
        w_pass     = 1'b0;
        w_adv_s    = 1'b0;

        if (i_pi == i_plen) begin
            o_done  = 1'b1;
            o_found = 1'b1;
        end else if (i_pc == CW'(META_STAR)) begin
            o_star_p   = i_pi + PW'(1);
            o_star_s   = i_si;
            o_sp_valid = 1'b1;
            o_pi       = i_pi + PW'(1);
        end else begin
            if (i_pc == CW'(META_CARET)) begin
                w_pass = (i_si == '0) || (i_sc_prev == CW'(META_SPACE));
            end else if (i_pc == CW'(META_DOLLAR)) begin
                w_pass = (i_si == i_slen) || (i_sc == CW'(META_SPACE));
            end else begin
                w_adv_s = 1'b1;
                w_pass  = (i_si < i_slen) &&
                          ((i_pc == CW'(META_DOT)) || (w_pc_cmp == w_sc_cmp));
            end

            if (w_pass) begin
                o_pi = i_pi + PW'(1);
                if (w_adv_s) begin
                    o_si = i_si + LW'(1);
                end
            end else if (i_sp_valid && (i_star_s < i_slen)) begin
                // Let the last '*' swallow one more character and retry after it.
                o_star_s = i_star_s + LW'(1);
                o_si     = i_star_s + LW'(1);
                o_pi     = i_star_p;
            end else begin
                // Candidate exhausted: slide the start; the empty tail at
                // st==slen is the last candidate worth trying.
                o_st       = i_st + LW'(1);
                o_si       = i_st + LW'(1);
                o_pi       = '0;
                o_sp_valid = 1'b0;
                if (i_st == i_slen) begin
                    o_done = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sme_param.sv
// Parametrised string-matching engine. Characters are loaded byte-serially
// into a string buffer and a pattern buffer; the first idle cycle after a
// pattern batch launches a leftmost-match search, one step per clock, whose
// result is presented for one cycle on valid/match/match_index.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    sme_if slave: chardata/isstring/ispattern in,
//          busy/valid/match/match_index out
module sme_param
    import sme_pkg::*;
#(
    parameter int CW      = 8,
    parameter int MAX_STR = 32,
    parameter int MAX_PAT = 8,
    parameter int NOCASE  = 0
) (
    input  logic  clk,
    input  logic  reset,
    sme_if.slave  bus
);

    // LW holds 0..MAX_STR+1 because the candidate start runs one past slen.
    localparam int LW  = $clog2(MAX_STR + 2);
    localparam int PW  = $clog2(MAX_PAT + 1);
    localparam int SAW = (MAX_STR > 1) ? $clog2(MAX_STR) : 1;
    localparam int PAW = (MAX_PAT > 1) ? $clog2(MAX_PAT) : 1;
    localparam int IW  = (MAX_STR > 1) ? $clog2(MAX_STR) : 1;

    logic [CW-1:0]  r_str [MAX_STR];
    logic [CW-1:0]  r_pat [MAX_PAT];
    logic [LW-1:0]  r_slen;
    logic [PW-1:0]  r_plen;
    logic           r_str_open;   // a string batch is in progress
    logic           r_pat_open;   // a pattern batch is in progress
    logic           r_pat_pend;   // pattern chars arrived since the last search

    state_e         r_state;
    state_e         w_state_n;

    logic [LW-1:0]  r_st;
    logic [LW-1:0]  r_si;
    logic [LW-1:0]  r_star_s;
    logic [PW-1:0]  r_pi;
    logic [PW-1:0]  r_star_p;
    logic           r_spv;
    logic           r_match;
    logic [IW-1:0]  r_idx;

    logic           w_load;
    logic           w_start;
    logic           w_str_we;
    logic           w_pat_we;
    logic [SAW-1:0] w_str_waddr;
    logic [PAW-1:0] w_pat_waddr;

    logic [CW-1:0]  w_pc;
    logic [CW-1:0]  w_sc;
    logic [CW-1:0]  w_sc_prev;
    logic [LW-1:0]  w_st_n;
    logic [LW-1:0]  w_si_n;
    logic [LW-1:0]  w_star_s_n;
    logic [PW-1:0]  w_pi_n;
    logic [PW-1:0]  w_star_p_n;
    logic           w_spv_n;
    logic           w_done;
    logic           w_found;

    assign w_load  = (r_state == LOAD);
    assign w_start = w_load && !bus.isstring && !bus.ispattern && r_pat_pend;

    // isstring has priority; the first char of a batch lands at address 0.
    assign w_str_we    = w_load && bus.isstring &&
                         (!r_str_open || (r_slen < LW'(MAX_STR)));
    assign w_pat_we    = w_load && bus.ispattern && !bus.isstring &&
                         (!r_pat_open || (r_plen < PW'(MAX_PAT)));
    assign w_str_waddr = r_str_open ? r_slen[SAW-1:0] : '0;
    assign w_pat_waddr = r_pat_open ? r_plen[PAW-1:0] : '0;

    always_ff @(posedge clk) begin
        if (w_str_we) begin
            r_str[w_str_waddr] <= bus.chardata;
        end
        if (w_pat_we) begin
            r_pat[w_pat_waddr] <= bus.chardata;
        end
    end

    // Out-of-range reads are masked so the step never sees stale buffer data.
    assign w_pc      = (r_pi < r_plen) ? r_pat[r_pi[PAW-1:0]] : '0;
    assign w_sc      = (r_si < r_slen) ? r_str[r_si[SAW-1:0]] : '0;
    assign w_sc_prev = (r_si != '0)    ? r_str[SAW'(r_si - LW'(1))] : '0;

    sme_step #(
        .CW     (CW),
        .LW     (LW),
        .PW     (PW),
        .NOCASE (NOCASE)
    ) u_step (
        .i_slen     (r_slen),
        .i_plen     (r_plen),
        .i_st       (r_st),
        .i_si       (r_si),
        .i_star_s   (r_star_s),
        .i_pi       (r_pi),
        .i_star_p   (r_star_p),
        .i_sp_valid (r_spv),
        .i_pc       (w_pc),
        .i_sc       (w_sc),
        .i_sc_prev  (w_sc_prev),
        .o_st       (w_st_n),
        .o_si       (w_si_n),
        .o_star_s   (w_star_s_n),
        .o_pi       (w_pi_n),
        .o_star_p   (w_star_p_n),
        .o_sp_valid (w_spv_n),
        .o_done     (w_done),
        .o_found    (w_found)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_n;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            LOAD:    if (w_start) w_state_n = SEARCH;
            SEARCH:  if (w_done)  w_state_n = DONE;
            DONE:    w_state_n = LOAD;
            default: w_state_n = LOAD;
        endcase
    end

    // FSM outputs: busy spans SEARCH and the DONE cycle, valid is DONE alone.
    always_comb begin
        bus.busy        = (r_state != LOAD);
        bus.valid       = (r_state == DONE);
        bus.match       = r_match;
        bus.match_index = r_idx;
    end

    // Lengths, batch tracking, search pointers and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slen     <= '0;
            r_plen     <= '0;
            r_str_open <= 1'b0;
            r_pat_open <= 1'b0;
            r_pat_pend <= 1'b0;
            r_st       <= '0;
            r_si       <= '0;
            r_star_s   <= '0;
            r_pi       <= '0;
            r_star_p   <= '0;
            r_spv      <= 1'b0;
            r_match    <= 1'b0;
            r_idx      <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (bus.isstring) begin
                        if (!r_str_open) begin
                            r_slen <= LW'(1);
                        end else if (r_slen < LW'(MAX_STR)) begin
                            r_slen <= r_slen + LW'(1);
                        end
                        r_str_open <= 1'b1;
                        r_pat_open <= 1'b0;
                    end else if (bus.ispattern) begin
                        if (!r_pat_open) begin
                            r_plen <= PW'(1);
                        end else if (r_plen < PW'(MAX_PAT)) begin
                            r_plen <= r_plen + PW'(1);
                        end
                        r_pat_open <= 1'b1;
                        r_pat_pend <= 1'b1;
                        r_str_open <= 1'b0;
                    end else if (r_pat_pend) begin
                        r_st       <= '0;
                        r_si       <= '0;
                        r_pi       <= '0;
                        r_spv      <= 1'b0;
                        r_pat_pend <= 1'b0;
                        r_pat_open <= 1'b0;
                        r_str_open <= 1'b0;
                    end
                end
                SEARCH: begin
                    r_st     <= w_st_n;
                    r_si     <= w_si_n;
                    r_star_s <= w_star_s_n;
                    r_pi     <= w_pi_n;
                    r_star_p <= w_star_p_n;
                    r_spv    <= w_spv_n;
                    if (w_done) begin
                        r_match <= w_found;
                        r_idx   <= w_found ? r_st[IW-1:0] : '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sme_param.sv
// Drives a case-sensitive and a case-insensitive sme_param with identical
// loads and checks both against a dynamic-programming reference matcher.
module tb_sme_param;

    localparam int CW = 8;
    localparam int MS = 32;
    localparam int MP = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sme_if #(.CW(CW), .MAX_STR(MS)) if0 ();
    sme_if #(.CW(CW), .MAX_STR(MS)) if1 ();

    sme_param #(.CW(CW), .MAX_STR(MS), .MAX_PAT(MP), .NOCASE(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    sme_param #(.CW(CW), .MAX_STR(MS), .MAX_PAT(MP), .NOCASE(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] m_str[$];
    logic [7:0] m_pat[$];
    bit         m_str_open;
    bit         m_pat_open;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lc(input logic [7:0] c, input bit nc);
        if (nc && c >= "A" && c <= "Z") return c + 8'd32;
        return c;
    endfunction

    // ok[s][p]: pattern suffix from p matches somewhere starting exactly at s.
    function automatic void ref_search(input bit nc, output bit m, output int idx);
        bit ok [0:MS+1][0:MP+1];
        int sl = m_str.size();
        int pl = m_pat.size();
        logic [7:0] c;
        for (int s = 0; s <= MS + 1; s++)
            for (int p = 0; p <= MP + 1; p++) ok[s][p] = 1'b0;
        for (int s = 0; s <= sl; s++) ok[s][pl] = 1'b1;
        for (int p = pl - 1; p >= 0; p--) begin
            c = m_pat[p];
            for (int s = sl; s >= 0; s--) begin
                if (c == "*")
                    ok[s][p] = ok[s][p+1] || (s < sl && ok[s+1][p]);
                else if (c == "^")
                    ok[s][p] = (s == 0 || m_str[s-1] == " ") && ok[s][p+1];
                else if (c == "$")
                    ok[s][p] = (s == sl || m_str[s] == " ") && ok[s][p+1];
                else
                    ok[s][p] = (s < sl) && (c == "." || lc(m_str[s], nc) == lc(c, nc)) && ok[s+1][p+1];
            end
        end
        m = 1'b0;
        idx = 0;
        for (int s = 0; s <= sl; s++) begin
            if (ok[s][0]) begin
                m = 1'b1;
                idx = s % MS;
                break;
            end
        end
    endfunction

    task automatic drive(input logic s, input logic p, input logic [7:0] c);
        if0.isstring = s; if0.ispattern = p; if0.chardata = c;
        if1.isstring = s; if1.ispattern = p; if1.chardata = c;
    endtask

    task automatic put_ch(input bit s, input bit p, input logic [7:0] c);
        @(negedge clk);
        drive(s, p, c);
        if (s) begin
            if (!m_str_open) m_str.delete();
            if (m_str.size() < MS) m_str.push_back(c);
            m_str_open = 1'b1;
            m_pat_open = 1'b0;
        end else if (p) begin
            if (!m_pat_open) m_pat.delete();
            if (m_pat.size() < MP) m_pat.push_back(c);
            m_pat_open = 1'b1;
            m_str_open = 1'b0;
        end
    endtask

    task automatic put_str(input string t);
        for (int i = 0; i < t.len(); i++) put_ch(1'b1, 1'b0, t[i]);
    endtask

    task automatic put_pat(input string t);
        for (int i = 0; i < t.len(); i++) put_ch(1'b0, 1'b1, t[i]);
    endtask

    task automatic run_search(input string tag);
        bit e0m, e1m, d0, d1;
        int e0i, e1i, n;
        ref_search(1'b0, e0m, e0i);
        ref_search(1'b1, e1m, e1i);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00);
        m_str_open = 1'b0;
        m_pat_open = 1'b0;
        @(negedge clk);
        check_val({tag, ":busy0"}, 32'(if0.busy), 32'd1);
        check_val({tag, ":busy1"}, 32'(if1.busy), 32'd1);
        d0 = 1'b0; d1 = 1'b0; n = 0;
        while (!(d0 && d1) && n < 2000) begin
            if (d0) check_val({tag, ":once0"}, 32'(if0.valid), 32'd0);
            else if (if0.valid) begin
                check_val({tag, ":match0"}, 32'(if0.match), 32'(e0m));
                check_val({tag, ":index0"}, 32'(if0.match_index), 32'(e0i));
                d0 = 1'b1;
            end
            if (d1) check_val({tag, ":once1"}, 32'(if1.valid), 32'd0);
            else if (if1.valid) begin
                check_val({tag, ":match1"}, 32'(if1.match), 32'(e1m));
                check_val({tag, ":index1"}, 32'(if1.match_index), 32'(e1i));
                d1 = 1'b1;
            end
            if (!(d0 && d1)) begin
                // Loads while busy must be ignored by both engines.
                if (if0.busy && if1.busy)
                    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(32, 126)));
                else
                    drive(1'b0, 1'b0, 8'h00);
                @(negedge clk);
                n++;
            end
        end
        drive(1'b0, 1'b0, 8'h00);
        if (!(d0 && d1)) check_val({tag, ":finished"}, {30'd0, d1, d0}, 32'd3);
        @(negedge clk);
        check_val({tag, ":vlow0"}, 32'(if0.valid), 32'd0);
        check_val({tag, ":vlow1"}, 32'(if1.valid), 32'd0);
        check_val({tag, ":idle0"}, 32'(if0.busy), 32'd0);
        check_val({tag, ":idle1"}, 32'(if1.busy), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        check_val({tag, ":busy"},  {31'd0, if0.busy  | if1.busy},  32'd0);
        check_val({tag, ":valid"}, {31'd0, if0.valid | if1.valid}, 32'd0);
        check_val({tag, ":match"}, {31'd0, if0.match | if1.match}, 32'd0);
        check_val({tag, ":index"}, 32'(if0.match_index | if1.match_index), 32'd0);
        reset = 1'b1;
        m_str.delete();
        m_pat.delete();
        m_str_open = 1'b0;
        m_pat_open = 1'b0;
    endtask

    initial begin
        string sa, pa;
        int k;
        reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        sa = "abAB ";
        pa = "abA.*^$ ";

        do_reset("por");

        put_str("hello world"); put_pat("wor");   run_search("t1_wor");
        put_pat("^w.r");                          run_search("t2_anchor");
        put_pat("lo$");                           run_search("t2_dollar");
        put_str("hello world"); put_pat("h*d$");  run_search("t3_star");
        put_pat("x*d");                           run_search("t3_nomatch");
        put_pat("e*o*r");                         run_search("t4_multistar");
        put_pat("**");                            run_search("t4_twostar");
        put_pat("LO W");                          run_search("t_nocase");
        put_pat("abcdefghij");                    run_search("t_patsat");

        do_reset("empty");
        put_pat("*");                             run_search("t4_empty_star");
        put_pat("^");                             run_search("t4_empty_caret");
        put_pat("a");                             run_search("t4_empty_a");

        for (int i = 0; i < 30; i++) put_ch(1'b1, 1'b0, "a");
        put_str("yzZZ");
        put_pat("Z");                             run_search("t5_dropped");
        put_pat("yz$");                           run_search("t5_tail");
        put_pat("YZ$");                           run_search("t5_tail_uc");

        // Both strobes high: the character belongs to the string.
        put_str("ba"); put_ch(1'b1, 1'b1, "c"); put_pat("ac");
        run_search("t_priority");

        // Abort a long search with reset.
        put_str("hello world"); put_pat("h*x");
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00);
        repeat (10) @(negedge clk);
        check_val("t6_busy_before", {31'd0, if0.busy & if1.busy}, 32'd1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("t6_abort_busy",  {31'd0, if0.busy  | if1.busy},  32'd0);
            check_val("t6_abort_valid", {31'd0, if0.valid | if1.valid}, 32'd0);
        end
        reset = 1'b1;
        m_str.delete(); m_pat.delete();
        m_str_open = 1'b0; m_pat_open = 1'b0;
        put_str("ab"); put_pat("b");              run_search("t6_reload");

        for (int it = 0; it < 40; it++) begin
            if (it == 0 || $urandom_range(0, 2) != 0) begin
                k = $urandom_range(0, 14);
                for (int i = 0; i < k; i++) put_ch(1'b1, 1'b0, sa[$urandom_range(0, sa.len() - 1)]);
            end
            k = $urandom_range(1, 10);
            for (int i = 0; i < k; i++) put_ch(1'b0, 1'b1, pa[$urandom_range(0, pa.len() - 1)]);
            run_search($sformatf("rnd%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
